// File: rtl/dm_cache_array_if.sv
//------------------------------------------------------------------------------
// Module  : dm_cache_array_if
// Brief   : CPU request, fill-stream and statistics bundle for dm_cache_array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dm_cache_array_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_write;
    logic [15:0]      req_addr;
    logic [15:0]      req_wdata;
    logic [15:0]      rd_data;
    logic             hit;
    logic             miss_detected;
    logic [15:0]      miss_address;
    logic             stall;
    logic             fsm_busy;
    logic             write_data_array;
    logic             write_tag_array;
    logic [15:0]      fill_address;
    logic [15:0]      fill_data;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    // Master is the CPU pipeline plus cache_fill_FSM; slave is the cache array.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output fsm_busy, write_data_array, write_tag_array, fill_address, fill_data,
        input  rd_data, hit, miss_detected, miss_address, stall, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  fsm_busy, write_data_array, write_tag_array, fill_address, fill_data,
        output rd_data, hit, miss_detected, miss_address, stall, hit_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/dm_cache_array.sv
//------------------------------------------------------------------------------
// Module  : dm_cache_array
// Brief   : Direct-mapped, write-through cache storage with tag match, miss
//           detection toward the fill FSM and saturating hit/miss statistics.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_cache_array #(
    parameter int IDX_W = 7,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    dm_cache_array_if.slave bus
);
    localparam int             c_lines   = 1 << IDX_W;
    localparam int             c_idx_lsb = 4;
    localparam int             c_tag_lsb = c_idx_lsb + IDX_W;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [15:0]      r_data  [c_lines][8];
    logic [TAG_W-1:0] r_tag   [c_lines];
    logic [c_lines-1:0] r_valid;
    logic             r_miss_q;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;

    logic [TAG_W-1:0] w_req_tag;
    logic [IDX_W-1:0] w_req_idx;
    logic [2:0]       w_req_word;
    logic [TAG_W-1:0] w_fill_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [2:0]       w_fill_word;
    logic             w_hit;
    logic             w_miss;
    logic             w_store_hit;
    logic             w_unused_ok;

    assign w_req_tag   = bus.req_addr[15:c_tag_lsb];
    assign w_req_idx   = bus.req_addr[c_tag_lsb-1:c_idx_lsb];
    assign w_req_word  = bus.req_addr[3:1];
    assign w_fill_tag  = bus.fill_address[15:c_tag_lsb];
    assign w_fill_idx  = bus.fill_address[c_tag_lsb-1:c_idx_lsb];
    assign w_fill_word = bus.fill_address[3:1];
    assign w_unused_ok = bus.req_addr[0] ^ bus.fill_address[0];

    assign w_hit       = bus.req_valid & r_valid[w_req_idx] & (r_tag[w_req_idx] == w_req_tag);
    assign w_miss      = bus.req_valid & ~w_hit;
    assign w_store_hit = w_hit & bus.req_write;

    assign bus.hit           = w_hit;
    assign bus.miss_detected = w_miss;
    assign bus.miss_address  = {bus.req_addr[15:4], 4'h0};
    assign bus.stall         = w_miss | bus.fsm_busy;
    assign bus.rd_data       = r_data[w_req_idx][w_req_word];
    assign bus.hit_count     = r_hit_count;
    assign bus.miss_count    = r_miss_count;

    // Storage arrays carry no reset; validity alone decides whether a line is usable.
    // The fill write is placed last so it overrides a colliding store to the same word.
    always_ff @(posedge clk) begin
        if (w_store_hit) begin
            r_data[w_req_idx][w_req_word] <= bus.req_wdata;
        end
        if (bus.write_data_array) begin
            r_data[w_fill_idx][w_fill_word] <= bus.fill_data;
        end
        if (bus.write_tag_array) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (bus.write_tag_array) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // A miss episode is counted once, on its first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_q     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_miss_q <= w_miss;
            if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + c_cnt_one;
            end
            if (w_miss && !r_miss_q && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + c_cnt_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_array.sv
//------------------------------------------------------------------------------
// Module  : tb_dm_cache_array
// Brief   : Scoreboard bench for dm_cache_array: directed fills, hits, misses,
//           reset mid-fill and hit-counter saturation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_cache_array;
    localparam int c_cnt_w = 16;

    localparam int F_HIT  = 0;
    localparam int F_MISS = 1;
    localparam int F_STALL = 2;
    localparam int F_MADDR = 3;
    localparam int F_RDATA = 4;
    localparam int F_HCNT = 5;
    localparam int F_MCNT = 6;

    typedef struct {
        int          cyc;
        string       name;
        int          field;
        logic [15:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cur_cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    dm_cache_array_if #(.CNT_W(c_cnt_w)) bus ();

    dm_cache_array #(
        .IDX_W(7),
        .TAG_W(5),
        .CNT_W(c_cnt_w)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cur_cyc = 0;
    always @(posedge clk) cur_cyc <= cur_cyc + 1;

    function automatic logic [15:0] actual(input int field);
        case (field)
            F_HIT:   return {15'd0, bus.hit};
            F_MISS:  return {15'd0, bus.miss_detected};
            F_STALL: return {15'd0, bus.stall};
            F_MADDR: return bus.miss_address;
            F_RDATA: return bus.rd_data;
            F_HCNT:  return bus.hit_count;
            default: return bus.miss_count;
        endcase
    endfunction

    // Monitor: pops every expectation queued for the current cycle.
    initial begin
        n_checks = 0;
        n_errors = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cur_cyc) begin
                exp_t        e;
                logic [15:0] act;
                e = sb.pop_front();
                n_checks++;
                if (e.cyc != cur_cyc) begin
                    n_errors++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cur_cyc);
                end else begin
                    act = actual(e.field);
                    if (act !== e.exp) begin
                        n_errors++;
                        $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", e.name, act, e.exp, cur_cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input int field, input logic [15:0] value);
        exp_t e;
        e.cyc   = cur_cyc;
        e.name  = name;
        e.field = field;
        e.exp   = value;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    // Eight fill words, tag strobe on the last; the held request stays a miss throughout.
    task automatic fill_line(input logic [15:0] base, input logic [15:0] dbase);
        for (int n = 0; n < 8; n++) begin
            bus.fsm_busy         = 1'b1;
            bus.write_data_array = 1'b1;
            bus.write_tag_array  = (n == 7);
            bus.fill_address     = base + 16'(2 * n);
            bus.fill_data        = dbase + 16'(n);
            if (n == 4) begin
                expect_v("fill_miss_held", F_MISS, 16'd1);
                expect_v("fill_stall", F_STALL, 16'd1);
            end
            if (n == 7) expect_v("fill_last_no_hit", F_HIT, 16'd0);
            step();
        end
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.fsm_busy         = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus.fsm_busy         = 1'b0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.fill_address     = 16'h0000;
        bus.fill_data        = 16'h0000;
        step();
        step();

        // 1: reset state, then a held load miss
        set_req(1'b1, 1'b0, 16'h000F, 16'h0000);
        expect_v("rst_hit", F_HIT, 16'd0);
        expect_v("rst_miss_eq_valid", F_MISS, 16'd1);
        expect_v("rst_hit_count", F_HCNT, 16'd0);
        expect_v("rst_miss_count", F_MCNT, 16'd0);
        step();
        rst_n = 1'b1;
        expect_v("m1_addr", F_MADDR, 16'h0000);
        expect_v("m1_stall", F_STALL, 16'd1);
        expect_v("m1_count_before", F_MCNT, 16'd0);
        step();
        expect_v("m1_count_after", F_MCNT, 16'd1);
        bus.fsm_busy = 1'b1;
        step();
        expect_v("m1_count_held", F_MCNT, 16'd1);
        expect_v("m1_stall_held", F_STALL, 16'd1);
        step();

        // 2: fill line 0
        fill_line(16'h0000, 16'h1000);
        expect_v("f1_hit", F_HIT, 16'd1);
        expect_v("f1_rdata", F_RDATA, 16'h1007);
        expect_v("f1_stall", F_STALL, 16'd0);
        expect_v("f1_miss", F_MISS, 16'd0);
        expect_v("f1_hit_count", F_HCNT, 16'd0);
        expect_v("f1_miss_count", F_MCNT, 16'd1);
        step();

        // 3: store hit, then loads
        set_req(1'b1, 1'b1, 16'h0004, 16'hBEEF);
        expect_v("st_old_rdata", F_RDATA, 16'h1002);
        expect_v("st_hit", F_HIT, 16'd1);
        expect_v("st_hit_count", F_HCNT, 16'd1);
        step();
        set_req(1'b1, 1'b0, 16'h0004, 16'h0000);
        expect_v("ld_stored", F_RDATA, 16'hBEEF);
        expect_v("ld_hit_count", F_HCNT, 16'd2);
        step();
        set_req(1'b1, 1'b0, 16'h0002, 16'h0000);
        expect_v("ld_untouched", F_RDATA, 16'h1001);
        step();

        // 4: conflict miss on index 0 with tag 1
        set_req(1'b1, 1'b0, 16'h0800, 16'h0000);
        expect_v("c_hit", F_HIT, 16'd0);
        expect_v("c_miss", F_MISS, 16'd1);
        expect_v("c_addr", F_MADDR, 16'h0800);
        expect_v("c_count_before", F_MCNT, 16'd1);
        step();
        expect_v("c_count_after", F_MCNT, 16'd2);
        step();
        fill_line(16'h0800, 16'h2000);
        expect_v("c_fill_hit", F_HIT, 16'd1);
        expect_v("c_fill_rdata", F_RDATA, 16'h2000);
        expect_v("c_hit_count", F_HCNT, 16'd4);
        step();
        set_req(1'b1, 1'b0, 16'h0000, 16'h0000);
        expect_v("c_evicted_hit", F_HIT, 16'd0);
        expect_v("c_evicted_miss", F_MISS, 16'd1);
        expect_v("c_evicted_addr", F_MADDR, 16'h0000);
        step();
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        expect_v("c_idle_miss", F_MISS, 16'd0);
        expect_v("c_miss_count3", F_MCNT, 16'd3);
        step();

        // 5: reset in the middle of a fill of index 1
        set_req(1'b1, 1'b0, 16'h0018, 16'h0000);
        bus.fsm_busy = 1'b1;
        step();
        for (int n = 0; n < 5; n++) begin
            bus.write_data_array = 1'b1;
            bus.fill_address     = 16'h0010 + 16'(2 * n);
            bus.fill_data        = 16'h3000 + 16'(n);
            step();
        end
        bus.write_data_array = 1'b0;
        bus.fsm_busy         = 1'b0;
        rst_n = 1'b0;
        expect_v("r_hit_count", F_HCNT, 16'd0);
        expect_v("r_miss_count", F_MCNT, 16'd0);
        expect_v("r_partial_hit", F_HIT, 16'd0);
        step();
        set_req(1'b1, 1'b0, 16'h0000, 16'h0000);
        expect_v("r_line0_hit", F_HIT, 16'd0);
        step();
        set_req(1'b1, 1'b0, 16'h0800, 16'h0000);
        expect_v("r_line0b_hit", F_HIT, 16'd0);
        step();
        rst_n = 1'b1;
        set_req(1'b1, 1'b0, 16'h0018, 16'h0000);
        expect_v("r_after_hit", F_HIT, 16'd0);
        expect_v("r_after_miss", F_MISS, 16'd1);
        expect_v("r_after_mcnt", F_MCNT, 16'd0);
        step();
        expect_v("r_after_mcnt1", F_MCNT, 16'd1);
        step();
        fill_line(16'h0010, 16'h4000);
        expect_v("r_refill_hit", F_HIT, 16'd1);
        expect_v("r_refill_rdata", F_RDATA, 16'h4004);
        expect_v("r_refill_hcnt", F_HCNT, 16'd0);

        // 6: hold the hit until the counter saturates
        repeat (100) step();
        expect_v("sat_mid", F_HCNT, 16'd100);
        repeat (65536 + 5 - 100) step();
        expect_v("sat_hit", F_HIT, 16'd1);
        expect_v("sat_count", F_HCNT, 16'hFFFF);
        step();
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        step();

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
